// File: rtl/md_unit_ctrl.sv
// Purpose : HI/LO multiply/divide controller. It runs a fixed-latency multiply or a
//           32-step restoring divide, owns HI/LO and raises the D-stage stall.
// Latency : MUL/MULTU take MUL_LAT cycles. DIV/DIVU take 33 cycles (32 steps + 1 fix-up).
//           MTHI/MTLO write at the edge that samples them.
// Backpr. : There is no queueing. The stall output keeps a second HI/LO-class
//           instruction in D while an operation is in flight. A start seen while busy
//           is dropped.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, op         E-stage md operation strobe and opcode
//                     (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op)
//   src_a, src_b      rs / rt operands
//   d_md_use          D-stage instruction touches HI/LO
//   busy              multiply or divide in flight
//   stall             combinational stall request to D
//   hi, lo            architectural HI/LO registers
module md_unit_ctrl #(
    parameter int MUL_LAT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [4:0]  r_cnt;
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic [31:0] r_src_a;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // op[0]==0 selects the signed flavour for both MULT/MULTU and DIV/DIVU.
    logic        w_sgn;
    logic        w_op_mul;
    logic        w_op_div;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_rem_sh;
    logic [31:0] w_rem_sub;
    logic        w_ge;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_sgn    = ~op[0];
    assign w_op_mul = (op[2:1] == 2'b00);
    assign w_op_div = (op[2:1] == 2'b01);

    // The low 64 bits of a 64x64 product of extended operands give the signed
    // or unsigned 32x32 product, depending on how the operands were extended.
    assign w_a_ext  = {{32{w_sgn & src_a[31]}}, src_a};
    assign w_b_ext  = {{32{w_sgn & src_b[31]}}, src_b};
    assign w_prod   = w_a_ext * w_b_ext;

    // The magnitude of 32'h80000000 is the same bit pattern read as unsigned.
    // That is why the overflow case wraps and does not trap.
    assign w_a_mag  = (w_sgn && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign w_b_mag  = (w_sgn && src_b[31]) ? (32'd0 - src_b) : src_b;

    // Restoring step. The shifted remainder needs a 33rd bit, because rem < divisor
    // only bounds the shifted value to below 2*divisor. The difference fits in 32 bits.
    assign w_rem_sh  = {r_rem, r_quo[31]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_rem_sub = w_rem_sh[31:0] - r_dvsr;

    assign w_quo_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
    assign w_rem_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;

    // Next-state logic. Only IDLE accepts a start, so a start seen while busy
    // has no effect.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && w_op_mul) begin
                    w_state_nxt = S_MUL;
                end else if (start && w_op_div) begin
                    w_state_nxt = S_DIV;
                end
            end
            S_MUL: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and HI/LO. HI/LO are written only at MTHI/MTLO, at the last MUL
    // edge or at the FIX edge. A reset part-way through therefore discards the
    // partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 5'd0;
            r_prod  <= 64'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_dvsr  <= 32'd0;
            r_src_a <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1: begin
                                r_prod <= w_prod;
                                r_cnt  <= MUL_CNT;
                            end
                            3'd2, 3'd3: begin
                                r_rem   <= 32'd0;
                                r_quo   <= w_a_mag;
                                r_dvsr  <= w_b_mag;
                                r_neg_q <= w_sgn & (src_a[31] ^ src_b[31]);
                                r_neg_r <= w_sgn & src_a[31];
                                r_div0  <= (src_b == 32'd0);
                                r_src_a <= src_a;
                                r_cnt   <= 5'd31;
                            end
                            3'd4: r_hi <= src_a;
                            3'd5: r_lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (r_cnt == 5'd0) begin
                        r_hi <= r_prod[63:32];
                        r_lo <= r_prod[31:0];
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_rem_sub : w_rem_sh[31:0];
                    r_quo <= {r_quo[30:0], w_ge};
                    if (r_cnt != 5'd0) begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_FIX: begin
                    if (r_div0) begin
                        r_lo <= 32'hFFFF_FFFF;
                        r_hi <= r_src_a;
                    end else begin
                        r_lo <= w_quo_fix;
                        r_hi <= w_rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    // The stall is raised already in the issue cycle. A D-stage HI/LO user then
    // never sees stale HI/LO, and never enters E behind a starting operation.
    assign stall = d_md_use & (busy | (start & ~op[2]));
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
